// File: rtl/mac_seq_ctrl.sv
// Purpose : sequences one C = A*B matrix multiply over external A/B read ports and a C write port.
// Latency : start sampled at cycle 0 -> RUN cycles 1..M*N*K, last c_we at M*N*K+3, done pulse at M*N*K+4.
// Backpressure: none; memories are fixed 1-cycle read latency and the C write port always accepts.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   start                 begin an operation (only looked at in IDLE)
//   abort                 cancel a running operation (exists only when MAC_ABORT_EN is defined)
//   busy, done            busy in RUN/DRAIN, one-cycle done pulse in DONE
//   a_re/b_re + addresses read side towards the A and B memories
//   data_in_a/data_in_b   read data, valid one cycle after the matching read enable
//   c_we + addr + c_data  write side towards the C memory
//
// Optional feature macro: MAC_ABORT_EN (adds the abort input and its cancel behaviour).

module mac_seq_ctrl #(
    parameter int M = 2,
    parameter int K = 2,
    parameter int N = 2,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K),
    localparam int AW_M = (M > 1) ? $clog2(M) : 1,
    localparam int AW_K = (K > 1) ? $clog2(K) : 1,
    localparam int AW_N = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
`ifdef MAC_ABORT_EN
    input  logic                                abort,
`endif
    output logic                                busy,
    output logic                                done,
    output logic                                a_re,
    output logic                                b_re,
    output logic [AW_M-1:0]                     a_row_addr,
    output logic [AW_K-1:0]                     a_col_addr,
    output logic [AW_K-1:0]                     b_row_addr,
    output logic [AW_N-1:0]                     b_col_addr,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
    output logic                                c_we,
    output logic [AW_M-1:0]                     c_row_addr,
    output logic [AW_N-1:0]                     c_col_addr,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] c_data
);

    localparam int PW = 2 * DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;

    // Terminal values of the three loop counters.
    localparam logic [AW_M-1:0] I_LAST = AW_M'(M - 1);
    localparam logic [AW_K-1:0] K_LAST = AW_K'(K - 1);
    localparam logic [AW_N-1:0] J_LAST = AW_N'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      drain_cnt;
    logic            re_q;
    logic [AW_M-1:0] i_cnt;
    logic [AW_K-1:0] k_cnt;
    logic [AW_N-1:0] j_cnt;

    logic            abort_req;
    logic            abort_hit;
    logic            last_issue;

`ifdef MAC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only acts while an operation is in flight; IDLE and DONE ignore it.
    assign abort_hit  = abort_req && ((state == RUN) || (state == DRAIN));
    assign last_issue = (i_cnt == I_LAST) && (j_cnt == J_LAST) && (k_cnt == K_LAST);

    // The read address ports are the loop counters themselves, so they
    // naturally hold their last value whenever the counters stop.
    assign a_re       = re_q;
    assign b_re       = re_q;
    assign a_row_addr = i_cnt;
    assign a_col_addr = k_cnt;
    assign b_row_addr = k_cnt;
    assign b_col_addr = j_cnt;

    // ------------------------------------------------------------------
    // Control FSM: owns state, read enable, loop counters, busy and done.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
            re_q      <= 1'b0;
            i_cnt     <= '0;
            k_cnt     <= '0;
            j_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with abort is treated as not requested.
                    if (start && !abort_req) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        re_q  <= 1'b1;
                        i_cnt <= '0;
                        k_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        re_q  <= 1'b0;
                    end else if (last_issue) begin
                        // Counters stay on the final address for the hold-last behaviour.
                        state     <= DRAIN;
                        re_q      <= 1'b0;
                        drain_cnt <= 2'd0;
                    end else if (k_cnt == K_LAST) begin
                        k_cnt <= '0;
                        if (j_cnt == J_LAST) begin
                            j_cnt <= '0;
                            i_cnt <= i_cnt + AW_M'(1);
                        end else begin
                            j_cnt <= j_cnt + AW_N'(1);
                        end
                    end else begin
                        k_cnt <= k_cnt + AW_K'(1);
                    end
                end
                DRAIN: begin
                    // Three cycles cover the data, product and accumulate stages
                    // of the final issue; its c_we lands in the last DRAIN cycle.
                    if (abort_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (drain_cnt == 2'd2) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    re_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: tags follow each issue through data (t+1), product (t+2)
    // and accumulate/write (registered at end of t+2, visible at t+3).
    // ------------------------------------------------------------------
    logic            s1_vld, s1_first, s1_last;
    logic [AW_M-1:0] s1_i;
    logic [AW_N-1:0] s1_j;
    logic            s2_vld, s2_first, s2_last;
    logic [AW_M-1:0] s2_i;
    logic [AW_N-1:0] s2_j;
    logic [PW-1:0]   prod;
    logic [RW-1:0]   acc;
    logic [RW-1:0]   prod_ext;
    logic [RW-1:0]   sum;

    // The result width includes $clog2(K) guard bits, so the running sum never overflows.
    always_comb begin
        prod_ext = RW'(prod);
        sum      = s2_first ? prod_ext : (acc + prod_ext);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_vld     <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_i       <= '0;
            s1_j       <= '0;
            s2_vld     <= 1'b0;
            s2_first   <= 1'b0;
            s2_last    <= 1'b0;
            s2_i       <= '0;
            s2_j       <= '0;
            prod       <= '0;
            acc        <= '0;
            c_we       <= 1'b0;
            c_row_addr <= '0;
            c_col_addr <= '0;
            c_data     <= '0;
        end else begin
            // Issue stage -> data stage: tags captured from the live counters.
            s1_vld   <= re_q && !abort_hit;
            s1_first <= (k_cnt == '0);
            s1_last  <= (k_cnt == K_LAST);
            s1_i     <= i_cnt;
            s1_j     <= j_cnt;

            // Data stage -> product stage: full-width unsigned product.
            s2_vld   <= s1_vld && !abort_hit;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_i     <= s1_i;
            s2_j     <= s1_j;
            prod     <= PW'(data_in_a) * PW'(data_in_b);

            // Product stage -> accumulator and C write port.
            c_we <= s2_vld && s2_last && !abort_hit;
            if (s2_vld && !abort_hit) begin
                acc <= sum;
                if (s2_last) begin
                    c_row_addr <= s2_i;
                    c_col_addr <= s2_j;
                    c_data     <= sum;
                end
            end
        end
    end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter M, default 2: rows of matrix A and C.
REQ-002 Parameter K, default 2: columns of A and rows of B (dot-product length), K>=1.
REQ-003 Parameter N, default 2: columns of B and C.
REQ-004 Parameter DATA_WIDTH_INIT_MATRIX, default 32: A/B element width, unsigned.
REQ-005 Parameter DATA_WIDTH_RESULT_MATRIX, default 2*DATA_WIDTH_INIT_MATRIX+$clog2(K): C element width.
REQ-006 Address widths SHALL be AW_M=max(1,$clog2(M)), AW_K=max(1,$clog2(K)), AW_N=max(1,$clog2(N)).
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 resetn  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  begin one C=A*B computation; sampled only in IDLE.
REQ-010 busy  out  1  high in RUN and DRAIN.
REQ-011 done  out  1  one-cycle pulse after the last C write.
REQ-012 a_re, b_re  out  1 each  read enables for the A and B memories.
REQ-013 a_row_addr  out  AW_M; a_col_addr  out  AW_K; b_row_addr  out  AW_K; b_col_addr  out  AW_N  read addresses.
REQ-014 data_in_a, data_in_b  in  DATA_WIDTH_INIT_MATRIX  read data, valid exactly 1 cycle after the matching re.
REQ-015 c_we  out  1  write strobe for the C memory.
REQ-016 c_row_addr  out  AW_M; c_col_addr  out  AW_N; c_data  out  DATA_WIDTH_RESULT_MATRIX  C write address and data.
REQ-017 abort  in  1  cancel the operation; present only when MAC_ABORT_EN is defined.

Function
REQ-018 FSM SHALL have states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN after the last read issue; DRAIN->DONE after 3 cycles; DONE->IDLE unconditionally.
REQ-019 In RUN the block SHALL assert a_re=b_re=1 every cycle with A(i,k), B(k,j); k innermost, then j, then i, all starting at 0.
REQ-020 Counters SHALL wrap: k at K-1 ->0 and j+1; j at N-1 ->0 and i+1; the issue at (M-1,N-1,K-1) is the last; RUN SHALL last exactly M*N*K cycles.
REQ-021 Outside RUN, a_re=b_re=0 and the addresses SHALL hold their last value.
REQ-022 Pipeline: issue at cycle t -> data valid at t+1 -> registered full-width product (2*DATA_WIDTH_INIT_MATRIX, unsigned) at t+2 -> accumulation at t+2, with first/last/i/j tags travelling with each stage.
REQ-023 The accumulator SHALL load the product when k==0 and add it otherwise, zero-extended to DATA_WIDTH_RESULT_MATRIX; no overflow is possible.
REQ-024 For k==K-1 the block SHALL assert c_we for one cycle at t+3 with c_row_addr=i, c_col_addr=j, c_data=final sum; exactly M*N writes per operation.
REQ-025 With start sampled at cycle 0: RUN occupies cycles 1..M*N*K, the last c_we occurs at M*N*K+3, done=1 at M*N*K+4, busy=1 in cycles 1..M*N*K+3.
REQ-026 start while not in IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored; start in the IDLE cycle following DONE SHALL be accepted.
REQ-027 K==1 SHALL produce c_data equal to the single product; M, N or K equal to 1 SHALL use 1-bit addresses driven 0.

Reset
REQ-028 resetn low SHALL immediately force IDLE, busy=0, done=0, a_re=b_re=0, c_we=0, all addresses/counters/pipeline valids/accumulator/c_data=0.
REQ-029 Reset mid-operation SHALL discard all in-flight products with no further c_we; a new start is required after release.

Configuration
REQ-030 With MAC_ABORT_EN defined, abort=1 in RUN or DRAIN SHALL return the FSM to IDLE on the next edge, clear pipeline valids, suppress any c_we from that edge on, and leave done=0.
REQ-031 With MAC_ABORT_EN defined, abort in IDLE or DONE SHALL have no effect, and start with abort in IDLE SHALL be ignored.
REQ-032 Without MAC_ABORT_EN the abort port SHALL not exist and every accepted start SHALL run to done.

Verification
REQ-033 M=K=N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at cycle 0 -> c_we at cycles 5,7,9,11 writing (0,0)=19,(0,1)=22,(1,0)=43,(1,1)=50; done at cycle 12.
REQ-034 Operands all 0xFFFFFFFF, K=2 -> every c_data = 2*(2^32-1)^2 = 0x1_FFFF_FFFC_0000_0002, with no truncation.
REQ-035 start pulsed at cycles 3 and 11 of the REQ-033 run -> both ignored; exactly 4 writes and one done pulse.
REQ-036 resetn low at cycle 6 of the REQ-033 run -> all outputs 0 at once, no c_we afterwards; a restart after release reproduces REQ-033 results.
REQ-037 MAC_ABORT_EN defined, abort at cycle 4 -> IDLE at cycle 5, no c_we at cycle 5 or later, done never asserted; a following start completes normally.
REQ-038 M=1, K=3, N=1, A=[2,3,4], B=[5,6,7] -> single c_we at cycle 6 with c_data=56; done at cycle 7.
